// File: rtl/arbitro_memoria_if.sv
// Requester-side bundle of arbitro_memoria: instruction fetch port and data
// (MEM stage) port, plus the shared address-error flag.
//   slave  : view used by the arbiter (requests in, responses out)
//   master : view used by the requesters (requests out, responses in)
// Signals:
//   inst_req/inst_end                     fetch request and word index
//   inst_pronto/inst_dado                 fetch completion pulse and word
//   dado_req/dado_esc/dado_end/dado_wdata data request, op, index, write data
//   dado_pronto/dado_rdata                data completion pulse and load word
//   erro_end                              index out of range, pulses with *_pronto
interface arbitro_memoria_if #(
    parameter int LARGURA = 32
);
    logic               inst_req;
    logic [LARGURA-1:0] inst_end;
    logic               inst_pronto;
    logic [LARGURA-1:0] inst_dado;
    logic               dado_req;
    logic               dado_esc;
    logic [LARGURA-1:0] dado_end;
    logic [LARGURA-1:0] dado_wdata;
    logic               dado_pronto;
    logic [LARGURA-1:0] dado_rdata;
    logic               erro_end;

    modport slave (
        input  inst_req, inst_end, dado_req, dado_esc, dado_end, dado_wdata,
        output inst_pronto, inst_dado, dado_pronto, dado_rdata, erro_end
    );

    modport master (
        output inst_req, inst_end, dado_req, dado_esc, dado_end, dado_wdata,
        input  inst_pronto, inst_dado, dado_pronto, dado_rdata, erro_end
    );
endinterface

// File: rtl/arbitro_memoria.sv
// Two-port arbiter in front of a single shared memory. The data port has
// priority; a pending fetch that has waited MAX_ESPERA cycles beats data.
// Every access runs OCIOSO -> ACESSO -> RESPOSTA -> OCIOSO and every output
// is registered.
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous reset, active low
//   bus           requester bundle (arbitro_memoria_if.slave)
//   mem_endereco  memory word index, held for the whole access
//   mem_indata    memory write data
//   mem_lerMem    read strobe, LAT_LEITURA cycles per read
//   mem_escMem    write strobe, 1 cycle per write
//   mem_output    memory read data
//   ocupado       1 whenever the FSM is not idle
module arbitro_memoria #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 512,
    parameter int LAT_LEITURA  = 1,
    parameter int MAX_ESPERA   = 3
) (
    input  logic               clock,
    input  logic               reset,
    arbitro_memoria_if.slave   bus,
    output logic [LARGURA-1:0] mem_endereco,
    output logic [LARGURA-1:0] mem_indata,
    output logic               mem_lerMem,
    output logic               mem_escMem,
    input  logic [LARGURA-1:0] mem_output,
    output logic               ocupado
);
    localparam int ESP_W = (MAX_ESPERA > 0) ? $clog2(MAX_ESPERA + 1) : 1;
    localparam int CNT_W = $clog2(LAT_LEITURA + 1);

    typedef enum logic [1:0] {OCIOSO, ACESSO, RESPOSTA} estado_t;

    estado_t            state_reg, state_next;
    logic               dono_inst_reg, dono_inst_next;   // 1 = fetch owns the access
    logic               esc_reg, esc_next;
    logic               erro_reg, erro_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [LARGURA-1:0] cap_reg, cap_next;               // read data for RESPOSTA
    logic [ESP_W-1:0]   espera_reg, espera_next;
    logic [LARGURA-1:0] endereco_reg, endereco_next;
    logic [LARGURA-1:0] indata_reg, indata_next;
    logic               ler_reg, ler_next;
    logic               escm_reg, escm_next;
    logic               inst_pronto_reg, inst_pronto_next;
    logic [LARGURA-1:0] inst_dado_reg, inst_dado_next;
    logic               dado_pronto_reg, dado_pronto_next;
    logic [LARGURA-1:0] dado_rdata_reg, dado_rdata_next;
    logic               erro_end_reg, erro_end_next;
    logic               ocupado_reg, ocupado_next;

    logic               grant_dado, grant_inst;
    logic [LARGURA-1:0] sel_end;
    logic               sel_esc;

    // Data wins unless fetch has waited long enough; only meaningful in OCIOSO.
    assign grant_dado = bus.dado_req && !(bus.inst_req && espera_reg == ESP_W'(MAX_ESPERA));
    assign grant_inst = !grant_dado && bus.inst_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= OCIOSO;
            dono_inst_reg   <= 1'b0;
            esc_reg         <= 1'b0;
            erro_reg        <= 1'b0;
            cnt_reg         <= '0;
            cap_reg         <= '0;
            espera_reg      <= '0;
            endereco_reg    <= '0;
            indata_reg      <= '0;
            ler_reg         <= 1'b0;
            escm_reg        <= 1'b0;
            inst_pronto_reg <= 1'b0;
            inst_dado_reg   <= '0;
            dado_pronto_reg <= 1'b0;
            dado_rdata_reg  <= '0;
            erro_end_reg    <= 1'b0;
            ocupado_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            dono_inst_reg   <= dono_inst_next;
            esc_reg         <= esc_next;
            erro_reg        <= erro_next;
            cnt_reg         <= cnt_next;
            cap_reg         <= cap_next;
            espera_reg      <= espera_next;
            endereco_reg    <= endereco_next;
            indata_reg      <= indata_next;
            ler_reg         <= ler_next;
            escm_reg        <= escm_next;
            inst_pronto_reg <= inst_pronto_next;
            inst_dado_reg   <= inst_dado_next;
            dado_pronto_reg <= dado_pronto_next;
            dado_rdata_reg  <= dado_rdata_next;
            erro_end_reg    <= erro_end_next;
            ocupado_reg     <= ocupado_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        dono_inst_next   = dono_inst_reg;
        esc_next         = esc_reg;
        erro_next        = erro_reg;
        cnt_next         = cnt_reg;
        cap_next         = cap_reg;
        endereco_next    = endereco_reg;
        indata_next      = indata_reg;
        ler_next         = 1'b0;
        escm_next        = 1'b0;
        inst_pronto_next = 1'b0;
        inst_dado_next   = inst_dado_reg;
        dado_pronto_next = 1'b0;
        dado_rdata_next  = dado_rdata_reg;
        erro_end_next    = 1'b0;
        sel_end          = grant_dado ? bus.dado_end : bus.inst_end;
        sel_esc          = grant_dado && bus.dado_esc;   // fetch is always a read

        case (state_reg)
            OCIOSO: begin
                if (grant_dado || grant_inst) begin
                    state_next     = ACESSO;
                    dono_inst_next = !grant_dado;
                    esc_next       = sel_esc;
                    erro_next      = !(sel_end < LARGURA'(PROFUNDIDADE));
                    cnt_next       = '0;
                    endereco_next  = sel_end;
                    indata_next    = bus.dado_wdata;
                    // Strobes are registered, so they rise together with ACESSO.
                    if (sel_end < LARGURA'(PROFUNDIDADE)) begin
                        ler_next  = !sel_esc;
                        escm_next = sel_esc;
                    end
                end
            end
            ACESSO: begin
                if (erro_reg) begin
                    cap_next   = '0;
                    state_next = RESPOSTA;
                end else if (esc_reg) begin
                    state_next = RESPOSTA;
                end else if (cnt_reg == CNT_W'(LAT_LEITURA - 1)) begin
                    // Last strobe cycle: memory output is valid now.
                    cap_next   = mem_output;
                    state_next = RESPOSTA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    ler_next = 1'b1;
                end
            end
            RESPOSTA: begin
                state_next    = OCIOSO;
                erro_end_next = erro_reg;
                if (dono_inst_reg) begin
                    inst_pronto_next = 1'b1;
                    inst_dado_next   = cap_reg;
                end else begin
                    dado_pronto_next = 1'b1;
                    if (!esc_reg) begin
                        dado_rdata_next = cap_reg;
                    end
                end
            end
            default: state_next = OCIOSO;
        endcase

        // Anti-starvation: count cycles a fetch is left waiting.
        if (!bus.inst_req || (state_reg == OCIOSO && grant_inst)) begin
            espera_next = '0;
        end else if (espera_reg != ESP_W'(MAX_ESPERA)) begin
            espera_next = espera_reg + ESP_W'(1);
        end else begin
            espera_next = espera_reg;
        end

        ocupado_next = (state_next != OCIOSO);
    end

    assign mem_endereco    = endereco_reg;
    assign mem_indata      = indata_reg;
    assign mem_lerMem      = ler_reg;
    assign mem_escMem      = escm_reg;
    assign ocupado         = ocupado_reg;
    assign bus.inst_pronto = inst_pronto_reg;
    assign bus.inst_dado   = inst_dado_reg;
    assign bus.dado_pronto = dado_pronto_reg;
    assign bus.dado_rdata  = dado_rdata_reg;
    assign bus.erro_end    = erro_end_reg;
endmodule

// File: tb/tb_arbitro_memoria.sv
// Scoreboard bench for arbitro_memoria: a LAT_LEITURA=1 instance exercises
// reset, priority, starvation and range errors; a LAT_LEITURA=3 instance
// exercises the multi-cycle read. Memory words start as 0x1000_0000 + index.
module tb_arbitro_memoria;
    localparam int L = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    arbitro_memoria_if #(.LARGURA(L)) bus ();
    arbitro_memoria_if #(.LARGURA(L)) bus2 ();

    logic [L-1:0] mem_endereco, mem_indata, mem_output;
    logic         mem_lerMem, mem_escMem, ocupado;
    logic [L-1:0] mem2_endereco, mem2_indata, mem2_output;
    logic         mem2_lerMem, mem2_escMem, ocupado2;

    arbitro_memoria #(.LARGURA(L), .PROFUNDIDADE(512), .LAT_LEITURA(1), .MAX_ESPERA(3)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave),
        .mem_endereco(mem_endereco), .mem_indata(mem_indata), .mem_lerMem(mem_lerMem),
        .mem_escMem(mem_escMem), .mem_output(mem_output), .ocupado(ocupado)
    );

    arbitro_memoria #(.LARGURA(L), .PROFUNDIDADE(512), .LAT_LEITURA(3), .MAX_ESPERA(3)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2.slave),
        .mem_endereco(mem2_endereco), .mem_indata(mem2_indata), .mem_lerMem(mem2_lerMem),
        .mem_escMem(mem2_escMem), .mem_output(mem2_output), .ocupado(ocupado2)
    );

    // Shared memory model: combinational read, synchronous write.
    logic [31:0] mem [512];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_escMem && mem_endereco < 512) begin
            mem[mem_endereco[8:0]] <= mem_indata;
        end
    end
    assign mem_output  = (mem_endereco  < 512) ? mem[mem_endereco[8:0]]  : '0;
    assign mem2_output = (mem2_endereco < 512) ? mem[mem2_endereco[8:0]] : '0;

    typedef struct {
        bit          inst;
        logic [31:0] dado;
        bit          chk_dado;
        bit          erro;
    } esp_t;

    esp_t fila[$];
    esp_t fila2[$];
    esp_t e_mon, e_mon2;
    int checks = 0;
    int failures = 0;
    int n_esc = 0, n_ler = 0, n_ler2 = 0, n_pronto = 0;
    bit end2_mudou = 1'b0;
    logic [31:0] end2_ant = '0;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", nome, got, exp);
        end
    endtask

    // Monitor for the LAT_LEITURA=1 instance.
    always @(negedge clock) begin
        if (mem_escMem) n_esc++;
        if (mem_lerMem) n_ler++;
        if (bus.inst_pronto || bus.dado_pronto) begin
            n_pronto++;
            if (fila.size() == 0) begin
                chk("pronto_inesperado", 32'(bus.inst_pronto | bus.dado_pronto), 32'd0);
            end else begin
                e_mon = fila.pop_front();
                chk("porta", 32'(bus.inst_pronto), 32'(e_mon.inst));
                chk("pronto_unico", 32'(bus.inst_pronto & bus.dado_pronto), 32'd0);
                if (e_mon.chk_dado)
                    chk("dado", e_mon.inst ? bus.inst_dado : bus.dado_rdata, e_mon.dado);
                chk("erro_end", 32'(bus.erro_end), 32'(e_mon.erro));
                $display("txn dut1 porta=%s dado=0x%08h rdata=0x%08h erro=%0b",
                         bus.inst_pronto ? "inst" : "dado", bus.inst_dado, bus.dado_rdata, bus.erro_end);
            end
        end
    end

    // Monitor for the LAT_LEITURA=3 instance.
    always @(negedge clock) begin
        if (mem2_escMem) chk("dut2_escMem", 32'd1, 32'd0);
        if (mem2_lerMem) begin
            n_ler2++;
            if (n_ler2 > 1 && mem2_endereco != end2_ant) end2_mudou = 1'b1;
            end2_ant = mem2_endereco;
        end
        if (bus2.inst_pronto || bus2.dado_pronto) begin
            if (fila2.size() == 0) begin
                chk("dut2_pronto_inesperado", 32'd1, 32'd0);
            end else begin
                e_mon2 = fila2.pop_front();
                chk("dut2_porta", 32'(bus2.inst_pronto), 32'(e_mon2.inst));
                if (e_mon2.chk_dado) chk("dut2_dado", bus2.inst_dado, e_mon2.dado);
                chk("dut2_erro_end", 32'(bus2.erro_end), 32'(e_mon2.erro));
                $display("txn dut2 porta=%s dado=0x%08h erro=%0b",
                         bus2.inst_pronto ? "inst" : "dado", bus2.inst_dado, bus2.erro_end);
            end
        end
    end

    // Counts negedges from now until the selected pronto is seen (bounded).
    task automatic espera_pronto(input bit dut2_sel, input bit inst, output int ciclos);
        bit visto;
        visto = 1'b0;
        ciclos = 0;
        for (int i = 0; i < 40 && !visto; i++) begin
            @(negedge clock);
            ciclos++;
            if (dut2_sel) visto = inst ? bus2.inst_pronto : bus2.dado_pronto;
            else          visto = inst ? bus.inst_pronto  : bus.dado_pronto;
        end
        if (!visto) chk("timeout_pronto", 32'd1, 32'd0);
    endtask

    // One data-port access on dut; latency counted as negedges from request.
    task automatic op_dado(input string nome, input bit esc, input logic [31:0] ender,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_erro,
                           input int exp_lat, input int exp_esc, input int exp_ler);
        int c;
        @(negedge clock);
        n_esc = 0;
        n_ler = 0;
        fila.push_back('{1'b0, exp_rd, !esc, exp_erro});
        bus.dado_req   = 1'b1;
        bus.dado_esc   = esc;
        bus.dado_end   = ender;
        bus.dado_wdata = wd;
        espera_pronto(1'b0, 1'b0, c);
        bus.dado_req = 1'b0;
        chk({nome, "_latencia"}, 32'(c), 32'(exp_lat));
        chk({nome, "_escMem_ciclos"}, 32'(n_esc), 32'(exp_esc));
        chk({nome, "_lerMem_ciclos"}, 32'(n_ler), 32'(exp_ler));
    endtask

    initial begin
        int c, base;
        bus.inst_req = 1'b0; bus.inst_end = '0;
        bus.dado_req = 1'b0; bus.dado_esc = 1'b0; bus.dado_end = '0; bus.dado_wdata = '0;
        bus2.inst_req = 1'b0; bus2.inst_end = '0;
        bus2.dado_req = 1'b0; bus2.dado_esc = 1'b0; bus2.dado_end = '0; bus2.dado_wdata = '0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_controle", 32'({ocupado, mem_lerMem, mem_escMem, bus.inst_pronto, bus.dado_pronto, bus.erro_end}), 32'd0);
        chk("reset_endereco", mem_endereco, 32'd0);
        chk("reset_rdata", bus.dado_rdata | bus.inst_dado, 32'd0);
        reset = 1'b1;

        // 1: reset during a read drops everything at once, no late pronto
        @(negedge clock);
        bus.dado_req = 1'b1; bus.dado_esc = 1'b0; bus.dado_end = 32'd3;
        @(posedge clock); #1;
        chk("t1_lerMem_ativo", 32'(mem_lerMem), 32'd1);
        reset = 1'b0;
        bus.dado_req = 1'b0;
        #1;
        chk("t1_reset_imediato", 32'({ocupado, mem_lerMem, mem_escMem, bus.inst_pronto, bus.dado_pronto}), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 base = n_pronto;
        repeat (6) @(negedge clock);
        #1 chk("t1_sem_pronto_apos_reset", 32'(n_pronto - base), 32'd0);

        // 2: write then read back word 5
        op_dado("t2_esc5", 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 3, 1, 0);
        op_dado("t2_ler5", 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 0, 1);

        // 3: simultaneous requests, data first then fetch of word 0
        @(negedge clock);
        fila.push_back('{1'b0, 32'h1000_0007, 1'b1, 1'b0});
        fila.push_back('{1'b1, 32'h1000_0000, 1'b1, 1'b0});
        bus.dado_req = 1'b1; bus.dado_esc = 1'b0; bus.dado_end = 32'd7;
        bus.inst_req = 1'b1; bus.inst_end = 32'd0;
        espera_pronto(1'b0, 1'b0, c);
        bus.dado_req = 1'b0;
        chk("t3_lat_dado", 32'(c), 32'd3);
        espera_pronto(1'b0, 1'b1, c);
        bus.inst_req = 1'b0;
        chk("t3_lat_inst", 32'(c), 32'd3);

        // 4: both held high; fetch must interleave with data
        @(negedge clock);
        fila.push_back('{1'b0, 32'h1000_0007, 1'b1, 1'b0});
        fila.push_back('{1'b1, 32'h1000_0001, 1'b1, 1'b0});
        fila.push_back('{1'b0, 32'h1000_0007, 1'b1, 1'b0});
        fila.push_back('{1'b1, 32'h1000_0001, 1'b1, 1'b0});
        bus.dado_req = 1'b1; bus.dado_esc = 1'b0; bus.dado_end = 32'd7;
        bus.inst_req = 1'b1; bus.inst_end = 32'd1;
        espera_pronto(1'b0, 1'b0, c);
        espera_pronto(1'b0, 1'b1, c);
        chk("t4_inst_apos_dado", 32'(c), 32'd3);
        espera_pronto(1'b0, 1'b0, c);
        espera_pronto(1'b0, 1'b1, c);
        bus.dado_req = 1'b0;
        bus.inst_req = 1'b0;
        chk("t4_inst_segunda_vez", 32'(c), 32'd3);

        // 5: out-of-range write and read
        op_dado("t5_esc512", 1'b1, 32'd512, 32'hCAFE_F00D, 32'd0, 1'b1, 3, 0, 0);
        chk("t5_mem0_intacto", mem[0], 32'h1000_0000);
        op_dado("t5_ler600", 1'b0, 32'd600, 32'd0, 32'd0, 1'b1, 3, 0, 0);

        // 6: LAT_LEITURA=3 fetch of word 2
        @(negedge clock);
        n_ler2 = 0;
        end2_mudou = 1'b0;
        fila2.push_back('{1'b1, 32'h1000_0002, 1'b1, 1'b0});
        bus2.inst_req = 1'b1; bus2.inst_end = 32'd2;
        espera_pronto(1'b1, 1'b1, c);
        bus2.inst_req = 1'b0;
        chk("t6_latencia", 32'(c), 32'd5);
        chk("t6_lerMem_ciclos", 32'(n_ler2), 32'd3);
        chk("t6_endereco_estavel", 32'(end2_mudou), 32'd0);
        chk("t6_endereco", end2_ant, 32'd2);

        repeat (3) @(negedge clock);
        chk("filas_vazias", 32'(fila.size() + fila2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
